// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the VRAM arbiter.
package vram_pkg;

  localparam int ADDR_W_DEF      = 19;
  localparam int DATA_W_DEF      = 12;
  localparam int WFIFO_DEPTH_DEF = 4;

  // i_rd_req to o_rd_valid, in clock cycles
  localparam int RD_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted-write register FIFO with registered full flag and sticky overflow.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             push_ok;
  logic             pop_ok;

  // A push against a full FIFO is dropped even if the same cycle pops.
  assign push_ok = i_push && !full_q;
  assign pop_ok  = i_pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
    ovf_d  = ovf_q | (i_push & full_q);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_empty = (count_q == '0);
  assign o_ovf   = ovf_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win, posted writes fill idle slots.
// Define VRAM_ARB_BLANK_WR_EN to drain writes only while i_active is low.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WFIFO_DEPTH = WFIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_active,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_push,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_full,
  output logic              o_wr_ovf,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(WFIFO_DEPTH) + 1;
  localparam int PIPE_W  = RD_LATENCY - 1;

  arb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [PIPE_W-1:0]    rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;

  logic [ENTRY_W-1:0]   fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 wr_allow;

`ifdef VRAM_ARB_BLANK_WR_EN
  assign wr_allow = !i_active;
`else
  logic unused_active;
  assign unused_active = i_active;
  assign wr_allow      = 1'b1;
`endif

  vram_wr_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_wr_push),
    .i_wdata ({i_wr_addr, i_wr_data}),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_count (fifo_count),
    .o_full  (o_wr_full),
    .o_empty (fifo_empty),
    .o_ovf   (o_wr_ovf)
  );

  // Decision for the command issued next cycle; address/data hold when idle.
  always_comb begin
    state_d     = ST_IDLE;
    fifo_pop    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (i_rd_req) begin
      state_d    = ST_RD;
      mem_addr_d = i_rd_addr;
    end else if ((fifo_count != '0) && !fifo_empty && wr_allow) begin
      state_d     = ST_WR;
      fifo_pop    = 1'b1;
      mem_addr_d  = fifo_head[ENTRY_W-1:DATA_W];
      mem_wdata_d = fifo_head[DATA_W-1:0];
    end
  end

  // Stage 0 marks the cycle the RAM returns data, the last stage is o_rd_valid.
  always_comb begin
    rd_pipe_d = {rd_pipe_q[PIPE_W-2:0], state_q == ST_RD};
    rd_data_d = rd_pipe_q[0] ? i_mem_rdata : rd_data_q;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pipe_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign o_mem_en    = (state_q != ST_IDLE);
  assign o_mem_we    = (state_q == ST_WR);
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rd_valid  = rd_pipe_q[PIPE_W-1];
  assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected RAM commands and read data are
// queued when stimulus is driven and matched as the DUT produces them.
module tb_vram_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_active;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_wr_push;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_full;
  logic          o_wr_ovf;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  exp_t rd_cmd_q [$];
  exp_t rd_dat_q [$];
  exp_t wr_cmd_q [$];

  vram_arbiter dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_active    (i_active),
    .i_rd_req    (i_rd_req),
    .i_rd_addr   (i_rd_addr),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .i_wr_push   (i_wr_push),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_wr_full   (o_wr_full),
    .o_wr_ovf    (o_wr_ovf),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents model; address 0x12345 yields 0xABC.
  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 12'h9F9;
  endfunction

  always @(posedge clk) begin
    if (o_mem_en && !o_mem_we) i_mem_rdata <= ram_f(o_mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (o_mem_en && !o_mem_we) begin
        $display("cyc %0d RD  addr 0x%05h", cyc, o_mem_addr);
        if (rd_cmd_q.size() == 0) chk("rd_cmd_unexpected", rd_cmd_q.size(), 1);
        else begin
          e = rd_cmd_q.pop_front();
          chk("rd_cmd_addr", o_mem_addr, e.addr);
          chk("rd_cmd_cyc", cyc, e.cyc);
        end
      end
      if (o_mem_en && o_mem_we) begin
        $display("cyc %0d WR  addr 0x%05h data 0x%03h", cyc, o_mem_addr, o_mem_wdata);
        if (wr_cmd_q.size() == 0) chk("wr_cmd_unexpected", wr_cmd_q.size(), 1);
        else begin
          e = wr_cmd_q.pop_front();
          chk("wr_cmd_addr", o_mem_addr, e.addr);
          chk("wr_cmd_data", o_mem_wdata, e.data);
          chk("wr_cmd_cyc", cyc, e.cyc);
        end
      end
      if (o_rd_valid) begin
        $display("cyc %0d RDV data 0x%03h", cyc, o_rd_data);
        if (rd_dat_q.size() == 0) chk("rd_valid_unexpected", rd_dat_q.size(), 1);
        else begin
          e = rd_dat_q.pop_front();
          chk("rd_data", o_rd_data, e.data);
          chk("rd_data_cyc", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; wr_cyc is the cycle the WR command is expected in.
  task automatic step(input bit rd, input logic [AW-1:0] ra, input bit wp,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit acc, input int wr_cyc);
    i_rd_req  = rd;
    i_rd_addr = ra;
    i_wr_push = wp;
    i_wr_addr = wa;
    i_wr_data = wd;
    if (rd) begin
      rd_cmd_q.push_back('{ra, 12'h000, 32'(cyc + 1)});
      rd_dat_q.push_back('{ra, ram_f(ra), 32'(cyc + 3)});
    end
    if (wp && acc) wr_cmd_q.push_back('{wa, wd, 32'(wr_cyc)});
    tick();
    i_rd_req  = 1'b0;
    i_wr_push = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int b = 0;
    while ((rd_cmd_q.size() + rd_dat_q.size() + wr_cmd_q.size()) != 0 && b < budget) begin
      tick();
      b++;
    end
    chk("drain_timeout", rd_cmd_q.size() + rd_dat_q.size() + wr_cmd_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"}, o_mem_en, 0);
    chk({tag, "_mem_we"}, o_mem_we, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    chk({tag, "_rd_valid"}, o_rd_valid, 0);
    chk({tag, "_rd_data"}, o_rd_data, 0);
    chk({tag, "_wr_full"}, o_wr_full, 0);
    chk({tag, "_wr_ovf"}, o_wr_ovf, 0);
  endtask

  initial begin
    int k;
    i_rst_n   = 1'b0;
    i_active  = 1'b0;
    i_rd_req  = 1'b0;
    i_rd_addr = '0;
    i_wr_push = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    repeat (3) tick();
    chk_all_zero("rst");
    i_rst_n = 1'b1;
    tick();

    // Single read of 0x12345, then a burst of back-to-back reads.
    step(1, 19'h12345, 0, '0, '0, 0, 0);
    wait_drain(10);
    for (int i = 0; i < 4; i++) step(1, AW'($urandom), 0, '0, '0, 0, 0);
    wait_drain(10);

    // Write some non-zero state, then reset while a read is on the bus.
    step(0, '0, 1, 19'h00ABC, 12'h123, 1, cyc + 2);
    wait_drain(10);
    i_rd_req  = 1'b1;
    i_rd_addr = 19'h0_7777;
    tick();
    i_rd_req  = 1'b0;
    chk("midrst_rd_on_bus", o_mem_en, 1);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    i_rst_n = 1'b1;
    repeat (6) tick();

    // Reads pre-empt a pending write.
    k = cyc;
    step(0, '0, 1, 19'h00010, 12'hF00, 1, k + 4);
    step(1, 19'h00400, 0, '0, '0, 0, 0);
    step(1, 19'h00401, 0, '0, '0, 0, 0);
    wait_drain(10);

    // Pointer wrap: ten pushes draining as they arrive.
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1, AW'(19'h00100 + i * 7), DW'($urandom), 1, cyc + 2);
      chk("wrap_full", o_wr_full, 0);
    end
    wait_drain(10);

    // Overflow: reads held while five pushes arrive; the fifth is dropped.
    k = cyc;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        chk("ovf_full_after4", o_wr_full, 1);
        chk("ovf_flag_before", o_wr_ovf, 0);
      end
      step(1, AW'(19'h00200 + i), 1, AW'(19'h00300 + i), DW'(12'hA00 + i), i < 4, k + 6 + i);
    end
    chk("ovf_flag_set", o_wr_ovf, 1);
    chk("ovf_full_held", o_wr_full, 1);
    wait_drain(20);
    chk("ovf_flag_sticky", o_wr_ovf, 1);
    chk("ovf_full_clear", o_wr_full, 0);

    // Write during active video.
    i_active = 1'b1;
    k = cyc;
`ifdef VRAM_ARB_BLANK_WR_EN
    step(0, '0, 1, 19'h00055, 12'h5A5, 1, k + 6);
    repeat (4) tick();
    i_active = 1'b0;
`else
    step(0, '0, 1, 19'h00055, 12'h5A5, 1, k + 2);
    repeat (3) tick();
    i_active = 1'b0;
`endif
    wait_drain(10);

    // Reset clears the sticky overflow flag.
    i_rst_n = 1'b0;
    #1;
    chk("rst2_wr_ovf", o_wr_ovf, 0);
    tick();
    i_rst_n = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
